spu_regfile_wb: RTL and testbench
=================================

// Module: spu_regfile_wb
// PURPOSE
//  - SPU register file: 128 x 128-bit registers.
//  - Sink for the execution pipes' writeback buses (rt_wb / rt_addr_wb / reg_write_wb).
//  - Source of the ra/rb/rc operands consumed by the pipes at the RF/FWD stage.
//  - Two writeback ports: even pipe (ev) and odd pipe (od, e.g. Permute).
//  - Three registered read ports with same-cycle writeback bypass.
//  - Sequential post-reset clear engine; operands are valid only once rf_ready is high.
// PARAMETERS
//  NUM_REGS  128  number of registers; also the clear length in cycles
//  ADDR_W    7    register address width, bit order [0:ADDR_W-1]
//  DATA_W    128  register width, bit order [0:DATA_W-1]
// PORTS
//  clk               in   1       clock, all state updates on posedge
//  reset             in   1       synchronous, active-high
//  ra_addr           in   ADDR_W  read port A address
//  rb_addr           in   ADDR_W  read port B address
//  rc_addr           in   ADDR_W  read port C address
//  ra                out  DATA_W  port A data, registered
//  rb                out  DATA_W  port B data, registered
//  rc                out  DATA_W  port C data, registered
//  rt_wb_ev          in   DATA_W  even-pipe writeback value
//  rt_addr_wb_ev     in   ADDR_W  even-pipe destination register
//  reg_write_wb_ev   in   1       even-pipe write enable
//  rt_wb_od          in   DATA_W  odd-pipe writeback value
//  rt_addr_wb_od     in   ADDR_W  odd-pipe destination register
//  reg_write_wb_od   in   1       odd-pipe write enable
//  rf_ready          out  1       clear done; reads and writes are honoured
//  wr_conflict       out  1       registered 1-cycle pulse: both ports wrote the same address
// BEHAVIOUR
//  - Reset values (reset high at a posedge): ra=rb=rc=0, rf_ready=0, wr_conflict=0.
//    Reset also loads state=CLEAR and clear counter cnt=0.
//  - FSM states: CLEAR, READY.
//  - CLEAR: each posedge writes reg[cnt]<=0 and increments cnt.
//    - The posedge that clears entry NUM_REGS-1 moves the FSM to READY.
//    - rf_ready=1 from the 128th posedge after reset deasserts.
//  - While in CLEAR:
//    - Both writeback ports are ignored.
//    - ra/rb/rc are held at 0.
//    - wr_conflict is held at 0.
//  - Reset asserted mid-CLEAR, or in READY, restarts CLEAR from cnt=0.
//  - READY write: on posedge, if reg_write_wb_x=1 then reg[rt_addr_wb_x]<=rt_wb_x.
//    - Both ports enabled with different addresses: both writes complete.
//    - Both ports enabled with the same address: od wins; wr_conflict=1 the next cycle.
//  - READY read: on posedge, each port loads from its sampled address, 1-cycle latency.
//  - Read bypass priority per port:
//    1. od write to the same address in the same cycle
//    2. ev write to the same address in the same cycle
//    3. array contents
//  - A port sees a same-edge write as already complete; no stale-read cycle exists.
//  - All three ports may read the same address; each returns identical data.
//  - No address is special. Addresses are full-width, so no wrap is possible.
//  - reg_write_wb_x=0 means rt_wb_x and rt_addr_wb_x are don't-care.
// TESTING
//  - Clear timing:
//    - Stimulus: hold reset 3 cycles, release.
//    - Response: rf_ready=0 for 127 posedges and 1 after the 128th.
//    - Every register then reads 0.
//  - Basic write/read:
//    - Stimulus: in READY, ev writes reg 5 = 128'hDEAD_BEEF.
//    - Response: one cycle later, ra_addr=5 yields ra=128'hDEAD_BEEF the following cycle.
//  - Bypass:
//    - Stimulus: in the same cycle, od writes reg 9 = 128'h1234 and rb_addr=rc_addr=9.
//    - Response: next cycle rb=rc=128'h1234.
//  - Conflict:
//    - Stimulus: ev writes reg 3 = 128'hAAAA and od writes reg 3 = 128'h5555, same cycle.
//    - Response: wr_conflict pulses high for exactly 1 cycle.
//    - Response: reg 3 reads 128'h5555.
//  - Reset mid-clear:
//    - Stimulus: pulse reset 1 cycle at clear cycle 60.
//    - Response: rf_ready rises 128 posedges after that reset deasserts.
//    - Response: writes issued during CLEAR are lost; the target reads 0.
//  - Dual write:
//    - Stimulus: ev writes reg 0 = 128'h1 and od writes reg 127 = 128'h2, same cycle.
//    - Response: reading ra_addr=0, rb_addr=127 gives ra=128'h1, rb=128'h2.
//    - Response: wr_conflict stays 0.

Source files
------------

// File: rtl/spu_regfile_wb_if.sv
// Bundle between the execution pipes and the SPU register file: operand reads,
// the two writeback buses and the register file status flags.
interface spu_regfile_wb_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 128
);
    logic [0:ADDR_W-1] ra_addr;
    logic [0:ADDR_W-1] rb_addr;
    logic [0:ADDR_W-1] rc_addr;
    logic [0:DATA_W-1] ra;
    logic [0:DATA_W-1] rb;
    logic [0:DATA_W-1] rc;
    logic [0:DATA_W-1] rt_wb_ev;
    logic [0:ADDR_W-1] rt_addr_wb_ev;
    logic              reg_write_wb_ev;
    logic [0:DATA_W-1] rt_wb_od;
    logic [0:ADDR_W-1] rt_addr_wb_od;
    logic              reg_write_wb_od;
    logic              rf_ready;
    logic              wr_conflict;

    modport master (
        output ra_addr, rb_addr, rc_addr,
        output rt_wb_ev, rt_addr_wb_ev, reg_write_wb_ev,
        output rt_wb_od, rt_addr_wb_od, reg_write_wb_od,
        input  ra, rb, rc, rf_ready, wr_conflict
    );

    modport slave (
        input  ra_addr, rb_addr, rc_addr,
        input  rt_wb_ev, rt_addr_wb_ev, reg_write_wb_ev,
        input  rt_wb_od, rt_addr_wb_od, reg_write_wb_od,
        output ra, rb, rc, rf_ready, wr_conflict
    );
endinterface

// File: rtl/spu_regfile_wb.sv
// SPU register file: two writeback ports, three registered read ports with
// same-edge write bypass, and a sequential clear engine after reset.
module spu_regfile_wb #(
    parameter int NUM_REGS = 128,
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 128
) (
    input  logic            clk,
    input  logic            reset,
    spu_regfile_wb_if.slave bus
);
    typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

    localparam logic [0:ADDR_W-1] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
    localparam logic [0:DATA_W-1] ZERO_DATA = {DATA_W{1'b0}};

    state_t            state_q, state_d;
    logic [0:ADDR_W-1] cnt_q, cnt_d;
    logic              rf_ready_q, rf_ready_d;
    logic              wr_conflict_q, wr_conflict_d;
    logic [0:DATA_W-1] ra_q, ra_d;
    logic [0:DATA_W-1] rb_q, rb_d;
    logic [0:DATA_W-1] rc_q, rc_d;
    logic              clr_en_s;
    logic              we_ev_s;
    logic              we_od_s;
    logic [0:DATA_W-1] mem_q [NUM_REGS];

    // The odd pipe outranks the even pipe, so a read matches the final array state.
    function automatic logic [0:DATA_W-1] read_mux(
        input logic [0:ADDR_W-1] addr,
        input logic [0:DATA_W-1] stored,
        input logic              ev_en,
        input logic [0:ADDR_W-1] ev_addr,
        input logic [0:DATA_W-1] ev_data,
        input logic              od_en,
        input logic [0:ADDR_W-1] od_addr,
        input logic [0:DATA_W-1] od_data
    );
        logic [0:DATA_W-1] result;
        if (od_en && (od_addr == addr)) begin
            result = od_data;
        end else if (ev_en && (ev_addr == addr)) begin
            result = ev_data;
        end else begin
            result = stored;
        end
        return result;
    endfunction

    // Next-state, write enables and read-port data selection.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rf_ready_d    = rf_ready_q;
        wr_conflict_d = 1'b0;
        ra_d          = ra_q;
        rb_d          = rb_q;
        rc_d          = rc_q;
        clr_en_s      = 1'b0;
        we_ev_s       = 1'b0;
        we_od_s       = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_en_s = 1'b1;
                cnt_d    = cnt_q + ADDR_W'(1);
                ra_d     = ZERO_DATA;
                rb_d     = ZERO_DATA;
                rc_d     = ZERO_DATA;
                if (cnt_q == LAST_ADDR) begin
                    state_d    = READY;
                    rf_ready_d = 1'b1;
                end else begin
                    state_d    = CLEAR;
                    rf_ready_d = 1'b0;
                end
            end
            READY: begin
                we_ev_s       = bus.reg_write_wb_ev;
                we_od_s       = bus.reg_write_wb_od;
                rf_ready_d    = 1'b1;
                wr_conflict_d = we_ev_s && we_od_s && (bus.rt_addr_wb_ev == bus.rt_addr_wb_od);
                ra_d = read_mux(bus.ra_addr, mem_q[bus.ra_addr],
                                we_ev_s, bus.rt_addr_wb_ev, bus.rt_wb_ev,
                                we_od_s, bus.rt_addr_wb_od, bus.rt_wb_od);
                rb_d = read_mux(bus.rb_addr, mem_q[bus.rb_addr],
                                we_ev_s, bus.rt_addr_wb_ev, bus.rt_wb_ev,
                                we_od_s, bus.rt_addr_wb_od, bus.rt_wb_od);
                rc_d = read_mux(bus.rc_addr, mem_q[bus.rc_addr],
                                we_ev_s, bus.rt_addr_wb_ev, bus.rt_wb_ev,
                                we_od_s, bus.rt_addr_wb_od, bus.rt_wb_od);
            end
            default: begin
                state_d    = CLEAR;
                cnt_d      = {ADDR_W{1'b0}};
                rf_ready_d = 1'b0;
                ra_d       = ZERO_DATA;
                rb_d       = ZERO_DATA;
                rc_d       = ZERO_DATA;
            end
        endcase
    end

    // FSM, clear counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= CLEAR;
            cnt_q         <= {ADDR_W{1'b0}};
            rf_ready_q    <= 1'b0;
            wr_conflict_q <= 1'b0;
            ra_q          <= ZERO_DATA;
            rb_q          <= ZERO_DATA;
            rc_q          <= ZERO_DATA;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rf_ready_q    <= rf_ready_d;
            wr_conflict_q <= wr_conflict_d;
            ra_q          <= ra_d;
            rb_q          <= rb_d;
            rc_q          <= rc_d;
        end
    end

    // Register array; the odd-pipe write is issued last so it wins a same-address clash.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (clr_en_s) begin
                mem_q[cnt_q] <= ZERO_DATA;
            end else begin
                if (we_ev_s) begin
                    mem_q[bus.rt_addr_wb_ev] <= bus.rt_wb_ev;
                end
                if (we_od_s) begin
                    mem_q[bus.rt_addr_wb_od] <= bus.rt_wb_od;
                end
            end
        end
    end

    assign bus.ra          = ra_q;
    assign bus.rb          = rb_q;
    assign bus.rc          = rc_q;
    assign bus.rf_ready    = rf_ready_q;
    assign bus.wr_conflict = wr_conflict_q;
endmodule

// File: tb/tb_spu_regfile_wb.sv
// Self-checking bench for spu_regfile_wb: directed vector table, clear/reset
// sequences and randomized traffic against a behavioural register-file model.
module tb_spu_regfile_wb;
    localparam int N = 128;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spu_regfile_wb_if #(.ADDR_W(7), .DATA_W(128)) bus();

    spu_regfile_wb #(.NUM_REGS(128), .ADDR_W(7), .DATA_W(128)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit           ev_en;
        int           ev_a;
        logic [127:0] ev_d;
        bit           od_en;
        int           od_a;
        logic [127:0] od_d;
        int           ra_a;
        int           rb_a;
        int           rc_a;
        logic [127:0] x_ra;
        logic [127:0] x_rb;
        logic [127:0] x_rc;
        bit           x_conf;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: register contents plus remaining clear cycles.
    logic [127:0] m_mem [N];
    int           m_clear_left;
    logic [127:0] e_ra, e_rb, e_rc;
    logic         e_rdy, e_conf;
    bit           chk_model;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_wb(input bit ev_en, input int ev_a, input logic [127:0] ev_d,
                            input bit od_en, input int od_a, input logic [127:0] od_d);
        bus.reg_write_wb_ev = ev_en;
        bus.rt_addr_wb_ev   = 7'(ev_a);
        bus.rt_wb_ev        = ev_d;
        bus.reg_write_wb_od = od_en;
        bus.rt_addr_wb_od   = 7'(od_a);
        bus.rt_wb_od        = od_d;
    endtask

    task automatic drive_rd(input int a, input int b, input int c);
        bus.ra_addr = 7'(a);
        bus.rb_addr = 7'(b);
        bus.rc_addr = 7'(c);
    endtask

    task automatic idle();
        drive_wb(1'b0, 0, 128'd0, 1'b0, 0, 128'd0);
    endtask

    // Predict the effect of the coming edge, take it, then compare.
    task automatic clk_edge();
        if (reset) begin
            foreach (m_mem[i]) m_mem[i] = 128'd0;
            m_clear_left = N;
            e_ra = 128'd0; e_rb = 128'd0; e_rc = 128'd0;
            e_rdy = 1'b0; e_conf = 1'b0;
        end else if (m_clear_left > 0) begin
            m_clear_left--;
            e_ra = 128'd0; e_rb = 128'd0; e_rc = 128'd0;
            e_conf = 1'b0;
            e_rdy  = (m_clear_left == 0);
        end else begin
            if (bus.reg_write_wb_ev) m_mem[bus.rt_addr_wb_ev] = bus.rt_wb_ev;
            if (bus.reg_write_wb_od) m_mem[bus.rt_addr_wb_od] = bus.rt_wb_od;
            e_ra   = m_mem[bus.ra_addr];
            e_rb   = m_mem[bus.rb_addr];
            e_rc   = m_mem[bus.rc_addr];
            e_conf = bus.reg_write_wb_ev && bus.reg_write_wb_od &&
                     (bus.rt_addr_wb_ev == bus.rt_addr_wb_od);
            e_rdy  = 1'b1;
        end
        @(posedge clk);
        #1;
        if (chk_model) begin
            check("model_ra", bus.ra, e_ra);
            check("model_rb", bus.rb, e_rb);
            check("model_rc", bus.rc, e_rc);
            check("model_rf_ready", {127'd0, bus.rf_ready}, {127'd0, e_rdy});
            check("model_wr_conflict", {127'd0, bus.wr_conflict}, {127'd0, e_conf});
        end
    endtask

    function automatic vec_t mk(input bit ev_en, input int ev_a, input logic [127:0] ev_d,
                                input bit od_en, input int od_a, input logic [127:0] od_d,
                                input int ra_a, input int rb_a, input int rc_a,
                                input logic [127:0] x_ra, input logic [127:0] x_rb,
                                input logic [127:0] x_rc, input bit x_conf);
        vec_t v;
        v.ev_en = ev_en; v.ev_a = ev_a; v.ev_d = ev_d;
        v.od_en = od_en; v.od_a = od_a; v.od_d = od_d;
        v.ra_a = ra_a; v.rb_a = rb_a; v.rc_a = rc_a;
        v.x_ra = x_ra; v.x_rb = x_rb; v.x_rc = x_rc; v.x_conf = x_conf;
        return v;
    endfunction

    initial begin
        vec_t tbl [9];
        int   n;

        tbl[0] = mk(1'b1, 5, 128'hDEAD_BEEF, 1'b0, 0, 128'd0, 0, 1, 2,
                    128'd0, 128'd0, 128'd0, 1'b0);
        tbl[1] = mk(1'b0, 0, 128'd0, 1'b0, 0, 128'd0, 5, 5, 6,
                    128'hDEAD_BEEF, 128'hDEAD_BEEF, 128'd0, 1'b0);
        tbl[2] = mk(1'b0, 0, 128'd0, 1'b1, 9, 128'h1234, 8, 9, 9,
                    128'd0, 128'h1234, 128'h1234, 1'b0);
        tbl[3] = mk(1'b1, 3, 128'hAAAA, 1'b1, 3, 128'h5555, 3, 9, 5,
                    128'h5555, 128'h1234, 128'hDEAD_BEEF, 1'b1);
        tbl[4] = mk(1'b0, 0, 128'd0, 1'b0, 0, 128'd0, 3, 3, 3,
                    128'h5555, 128'h5555, 128'h5555, 1'b0);
        tbl[5] = mk(1'b1, 0, 128'h1, 1'b1, 127, 128'h2, 0, 127, 1,
                    128'h1, 128'h2, 128'd0, 1'b0);
        tbl[6] = mk(1'b0, 0, 128'd0, 1'b0, 0, 128'd0, 0, 127, 127,
                    128'h1, 128'h2, 128'h2, 1'b0);
        tbl[7] = mk(1'b1, 10, 128'h77, 1'b1, 11, 128'h88, 10, 11, 12,
                    128'h77, 128'h88, 128'd0, 1'b0);
        tbl[8] = mk(1'b0, 5, 128'hFFFF, 1'b0, 5, 128'hEEEE, 5, 3, 10,
                    128'hDEAD_BEEF, 128'h5555, 128'h77, 1'b0);

        chk_model    = 1'b1;
        m_clear_left = N;
        reset        = 1'b1;
        idle();
        drive_rd(0, 0, 0);

        // Clear timing after a 3-cycle reset.
        repeat (3) clk_edge();
        reset = 1'b0;
        n = 0;
        while (bus.rf_ready !== 1'b1 && n < 300) begin
            clk_edge();
            n++;
        end
        check("clear_len", 128'(n), 128'd128);

        // Every register reads zero after the clear.
        for (int i = 0; i < N; i++) begin
            drive_rd(i, i, N - 1 - i);
            clk_edge();
            check("zero_ra", bus.ra, 128'd0);
        end

        // Directed vector table.
        chk_model = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive_wb(tbl[i].ev_en, tbl[i].ev_a, tbl[i].ev_d, tbl[i].od_en, tbl[i].od_a, tbl[i].od_d);
            drive_rd(tbl[i].ra_a, tbl[i].rb_a, tbl[i].rc_a);
            clk_edge();
            check($sformatf("vec%0d_ra", i), bus.ra, tbl[i].x_ra);
            check($sformatf("vec%0d_rb", i), bus.rb, tbl[i].x_rb);
            check($sformatf("vec%0d_rc", i), bus.rc, tbl[i].x_rc);
            check($sformatf("vec%0d_conf", i), {127'd0, bus.wr_conflict}, {127'd0, tbl[i].x_conf});
        end
        idle();
        chk_model = 1'b1;

        // Reset mid-clear with writes issued during the clear.
        reset = 1'b1;
        clk_edge();
        reset = 1'b0;
        repeat (30) clk_edge();
        drive_wb(1'b1, 20, 128'hBEEF, 1'b1, 21, 128'hCAFE);
        clk_edge();
        idle();
        repeat (29) clk_edge();
        reset = 1'b1;
        clk_edge();
        reset = 1'b0;
        n = 0;
        while (bus.rf_ready !== 1'b1 && n < 300) begin
            if (n == 10) drive_wb(1'b1, 20, 128'hF00D, 1'b0, 0, 128'd0);
            else idle();
            clk_edge();
            n++;
        end
        check("midclear_len", 128'(n), 128'd128);
        idle();
        drive_rd(20, 21, 20);
        clk_edge();
        check("lost_write_ra", bus.ra, 128'd0);
        check("lost_write_rb", bus.rb, 128'd0);

        // Randomized traffic, biased to a small address window to provoke bypass and conflicts.
        for (int i = 0; i < 600; i++) begin
            int           sel;
            logic [127:0] d0, d1;
            sel = int'($urandom_range(0, 3));
            d0  = {$urandom, $urandom, $urandom, $urandom};
            d1  = {$urandom, $urandom, $urandom, $urandom};
            if (sel != 0) begin
                drive_wb($urandom_range(0, 1) == 1, int'($urandom_range(0, 7)), d0,
                         $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)), d1);
                drive_rd(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                         int'($urandom_range(0, 7)));
            end else begin
                drive_wb($urandom_range(0, 1) == 1, int'($urandom_range(0, 127)), d0,
                         $urandom_range(0, 1) == 1, int'($urandom_range(0, 127)), d1);
                drive_rd(int'($urandom_range(0, 127)), int'($urandom_range(0, 127)),
                         int'($urandom_range(0, 127)));
            end
            clk_edge();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end
endmodule
